// File: rtl/fixed_mult_if.sv
`default_nettype none
// ============================================================================
// Module   : fixed_mult_if
// Purpose  : Start/busy/done handshake bundle for the sequential fixed-point
//            multiplier.
// Ports    : master - drives start, a, b; observes busy, done, res, ovf
//            slave  - the multiplier side of the same signals
// Revision : 1.0 - initial release
// ============================================================================
interface fixed_mult_if #(
  parameter int nBits = 32
);
  logic             start;
  logic [nBits-1:0] a;
  logic [nBits-1:0] b;
  logic             busy;
  logic             done;
  logic [nBits-1:0] res;
  logic             ovf;

  modport master (output start, a, b, input busy, done, res, ovf);
  modport slave  (input start, a, b, output busy, done, res, ovf);
endinterface
`default_nettype wire

// File: rtl/fixed_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : fixed_mult_seq
// Purpose  : Sequential signed fixed-point multiplier, Q(nBits-FRAC).FRAC
//            two's complement, one radix-2 shift-add step per clock.
//            Magnitudes are multiplied unsigned, the product is truncated
//            toward zero by dropping FRAC bits, then the sign is reapplied.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous reset, active-low
//            bus    - fixed_mult_if.slave (start, a, b in; busy, done,
//                     res, ovf out)
// Options  : FIXED_MULT_SATURATE_EN - when defined, res clamps to the
//            representable range on overflow; otherwise res wraps.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_mult_seq #(
  parameter int nBits = 32,
  parameter int FRAC  = 15
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  fixed_mult_if.slave   bus
);

  localparam int CW = $clog2(nBits + 1);
  localparam logic [2*nBits-1:0] C_MAX_POS = {{(nBits+1){1'b0}}, {(nBits-1){1'b1}}};
  localparam logic [2*nBits-1:0] C_MIN_MAG = {{(nBits){1'b0}}, 1'b1, {(nBits-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_last;

  logic [CW-1:0]       r_cnt;
  logic [2*nBits-1:0]  r_mcand;   // shifted left each step instead of a barrel shift
  logic [2*nBits-1:0]  r_acc;
  logic [nBits-1:0]    r_mplier;
  logic                r_sgn;
  logic [nBits-1:0]    r_res;
  logic                r_ovf;

  logic [nBits-1:0]    w_abs_a;
  logic [nBits-1:0]    w_abs_b;
  logic [2*nBits-1:0]  w_m;
  logic                w_ovf;
  logic [nBits-1:0]    w_wrap;
  logic [nBits-1:0]    w_res;

  // Negating the most negative value yields 2^(nBits-1) read as unsigned.
  assign w_abs_a = bus.a[nBits-1] ? -bus.a : bus.a;
  assign w_abs_b = bus.b[nBits-1] ? -bus.b : bus.b;

  // The cycle after the last shift-add step commits the result.
  assign w_last  = (r_cnt == CW'(nBits));

  assign w_m     = r_acc >> FRAC;
  assign w_ovf   = r_sgn ? (w_m > C_MIN_MAG) : (w_m > C_MAX_POS);
  // -0 is 0 in two's complement, so no negative zero can appear.
  assign w_wrap  = r_sgn ? -w_m[nBits-1:0] : w_m[nBits-1:0];

`ifdef FIXED_MULT_SATURATE_EN
  assign w_res   = !w_ovf ? w_wrap :
                   r_sgn  ? {1'b1, {(nBits-1){1'b0}}} : {1'b0, {(nBits-1){1'b1}}};
`else
  assign w_res   = w_wrap;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = FIN;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_sgn    <= 1'b0;
      r_res    <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{nBits{1'b0}}, w_abs_a};
      r_mplier <= w_abs_b;
      r_sgn    <= bus.a[nBits-1] ^ bus.b[nBits-1];
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      if (w_last) begin
        r_res <= w_res;
        r_ovf <= w_ovf;
      end else begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == FIN);
  assign bus.res  = r_res;
  assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fixed_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_mult_seq
// Purpose  : Self-checking bench for fixed_mult_seq. A driver issues directed
//            operations and queues the hand-computed result; a monitor pops
//            and compares whenever done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_mult_seq;

  logic clk;
  logic rst_n;

  fixed_mult_if #(.nBits(32)) bus ();

  fixed_mult_seq #(.nBits(32), .FRAC(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("res", bus.res, e.res);
        check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
      end
    end
  end

  // mode 0: single-cycle start; 1: start held 3 cycles with changing
  // operands; 2: extra start pulse while busy. exp_lat>0 checks latency.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eo,
                       input int mode, input int exp_lat);
    int lat;
    while (bus.busy || bus.done) @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back({er, eo});
    if (mode == 1) begin
      @(negedge clk);
      bus.a = 32'h7FFFFFFF;
      bus.b = 32'h7FFFFFFF;
      @(negedge clk);
      bus.a = 32'h80000000;
      bus.b = 32'h00010000;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.a     = 32'h12345678;
    bus.b     = 32'h9ABCDEF0;
    if (mode == 2) begin
      repeat (5) @(negedge clk);
      bus.a     = 32'h7FFFFFFF;
      bus.b     = 32'h7FFFFFFF;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) begin
      check("done_timeout", 32'd0, 32'd1);
    end else if (exp_lat > 0) begin
      check("latency", lat, exp_lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_res",  bus.res, 32'd0);
    check("rst_ovf",  {31'd0, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.5*2.0; done appears in the 34th cycle after the accept edge
    do_op(32'h0000C000, 32'h00010000, 32'h00018000, 1'b0, 0, 34);
    do_op(32'hFFFF4000, 32'h00010000, 32'hFFFE8000, 1'b0, 0, 0);
    do_op(32'h00010000, 32'hFFFF4000, 32'hFFFE8000, 1'b0, 0, 0);
    // truncation toward zero
    do_op(32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 0, 0);
    do_op(32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 0, 0);
    // (2^31-1)^2 >> 15 = 0x7FFF_FFFE_0000
`ifdef FIXED_MULT_SATURATE_EN
    do_op(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 0, 0);
`else
    do_op(32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFE0000, 1'b1, 0, 0);
`endif
    // -65536 * 1.0: magnitude exactly 2^31 with negative sign fits
    do_op(32'h80000000, 32'h00008000, 32'h80000000, 1'b0, 0, 0);
    // -1.0 * -1.0
    do_op(32'hFFFF8000, 32'hFFFF8000, 32'h00008000, 1'b0, 0, 0);
    // -65536 * 2.0: magnitude 2^32, negative overflow
`ifdef FIXED_MULT_SATURATE_EN
    do_op(32'h80000000, 32'h00010000, 32'h80000000, 1'b1, 0, 0);
`else
    do_op(32'h80000000, 32'h00010000, 32'h00000000, 1'b1, 0, 0);
`endif
    // start held 3 cycles: only the first operands count
    do_op(32'h0000C000, 32'h00010000, 32'h00018000, 1'b0, 1, 0);
    // start pulsed during busy is ignored: 2.0*2.0
    do_op(32'h00010000, 32'h00010000, 32'h00020000, 1'b0, 2, 0);

    // reset in the middle of RUN
    while (bus.busy || bus.done) @(negedge clk);
    bus.a     = 32'h7FFFFFFF;
    bus.b     = 32'h00010000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_res",  bus.res, 32'd0);
    check("abort_ovf",  {31'd0, bus.ovf}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    // 3.0*0.5
    do_op(32'h00018000, 32'h00004000, 32'h0000C000, 1'b0, 0, 34);

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
